// File: rtl/ber_counter_mc.sv
// ber_counter_mc: multi-lane BER counter. Each lane searches for the latency that aligns
// the received bits with a local PRBS reference, then accumulates error and total counts
// while watching a monitor window for loss of sync, re-entering search when it trips.
module ber_counter_mc #(
  parameter int unsigned  NCH       = 2,
  parameter int unsigned  PRBS_LEN  = 511,
  parameter int unsigned  START_SYN = 0,
  parameter int unsigned  SYN_WIN   = 511,
  parameter int unsigned  SYN_THR   = 0,
  parameter int unsigned  MON_WIN   = 1024,
  parameter int unsigned  LOS_THR   = 64,
  parameter int unsigned  NBT_CNT   = 64,
  localparam int unsigned NBT_LAT   = $clog2(PRBS_LEN)
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_clear,
  input  logic [NCH-1:0]         i_ref,
  input  logic [NCH-1:0]         i_rx,
  output logic [NCH-1:0]         o_lock,
  output logic [NCH*NBT_LAT-1:0] o_lat,
  output logic [NCH*NBT_CNT-1:0] o_err,
  output logic [NCH*NBT_CNT-1:0] o_tot,
  output logic [NCH*8-1:0]       o_los_cnt
);

  localparam int unsigned IdleW = (START_SYN > 1) ? $clog2(START_SYN) : 1;
  localparam int unsigned WinW  = (SYN_WIN > 1) ? $clog2(SYN_WIN) : 1;
  localparam int unsigned WerrW = $clog2(SYN_WIN + 1);
  localparam int unsigned MonW  = (MON_WIN > 1) ? $clog2(MON_WIN) : 1;
  localparam int unsigned MerrW = $clog2(MON_WIN + 1);

  localparam logic [NBT_LAT-1:0] LatMax  = NBT_LAT'(PRBS_LEN - 1);
  localparam logic [WinW-1:0]    WinLast = WinW'(SYN_WIN - 1);
  localparam logic [MonW-1:0]    MonLast = MonW'(MON_WIN - 1);
  localparam logic [IdleW-1:0]   IdleLast = IdleW'(START_SYN - 1);

  typedef enum logic [1:0] {StIdle, StSearch, StLock} state_e;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    state_e              state_q, state_d;
    logic [NBT_LAT-1:0]  lat_q, lat_d, lat_inc;
    logic [IdleW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [WinW-1:0]     win_cnt_q, win_cnt_d;
    logic [WerrW-1:0]    win_err_q, win_err_d;
    logic [MonW-1:0]     mon_cnt_q, mon_cnt_d;
    logic [MerrW-1:0]    mon_err_q, mon_err_d;
    logic [NBT_CNT-1:0]  err_q, err_d, tot_q, tot_d;
    logic [7:0]          los_q, los_d;
    logic [PRBS_LEN-2:0] sr_q;
    logic [PRBS_LEN-1:0] ref_vec;
    logic [31:0]         syn_final, mon_final;
    logic                mis;
    logic                lock;

    // Tap 0 is the current reference bit, tap k the bit k strobes earlier.
    assign ref_vec = {sr_q, i_ref[g]};
    assign mis     = i_enable & (i_rx[g] ^ ref_vec[lat_q]);
    assign lat_inc = (lat_q == LatMax) ? '0 : lat_q + 1'b1;

    // State, latency, window, accumulator and delay-line registers
    always_ff @(posedge clk) begin
      if (i_reset) begin
        state_q    <= StIdle;
        lat_q      <= '0;
        idle_cnt_q <= '0;
        win_cnt_q  <= '0;
        win_err_q  <= '0;
        mon_cnt_q  <= '0;
        mon_err_q  <= '0;
        err_q      <= '0;
        tot_q      <= '0;
        los_q      <= '0;
        sr_q       <= '0;
      end else begin
        state_q    <= state_d;
        lat_q      <= lat_d;
        idle_cnt_q <= idle_cnt_d;
        win_cnt_q  <= win_cnt_d;
        win_err_q  <= win_err_d;
        mon_cnt_q  <= mon_cnt_d;
        mon_err_q  <= mon_err_d;
        err_q      <= err_d;
        tot_q      <= tot_d;
        los_q      <= los_d;
        if (i_enable) begin
          sr_q <= ref_vec[PRBS_LEN-2:0];
        end
      end
    end

    // Next-state: search/lock transitions, window bookkeeping and saturating counts
    always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      idle_cnt_d = idle_cnt_q;
      win_cnt_d  = win_cnt_q;
      win_err_d  = win_err_q;
      mon_cnt_d  = mon_cnt_q;
      mon_err_d  = mon_err_q;
      err_d      = err_q;
      tot_d      = tot_q;
      los_d      = los_q;
      // Window totals including the mismatch of the closing strobe
      syn_final  = 32'(win_err_q) + 32'(mis);
      mon_final  = 32'(mon_err_q) + 32'(mis);

      unique case (state_q)
        StIdle: begin
          if (START_SYN == 0) begin
            state_d = StSearch;
          end else if (i_enable) begin
            if (idle_cnt_q == IdleLast) begin
              state_d    = StSearch;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
        end
        StSearch: begin
          if (i_enable) begin
            if (win_cnt_q == WinLast) begin
              win_cnt_d = '0;
              win_err_d = '0;
              if (syn_final <= SYN_THR) begin
                state_d   = StLock;
                mon_cnt_d = '0;
                mon_err_d = '0;
              end else begin
                lat_d = lat_inc;
              end
            end else begin
              win_cnt_d = win_cnt_q + 1'b1;
              win_err_d = win_err_q + WerrW'(mis);
            end
          end
        end
        StLock: begin
          if (i_enable) begin
            if (tot_q != '1) begin
              tot_d = tot_q + 1'b1;
            end
            if (mis && (err_q != '1)) begin
              err_d = err_q + 1'b1;
            end
            if (mon_cnt_q == MonLast) begin
              mon_cnt_d = '0;
              mon_err_d = '0;
              if (mon_final > LOS_THR) begin
                state_d   = StSearch;
                lat_d     = lat_inc;
                win_cnt_d = '0;
                win_err_d = '0;
                if (los_q != '1) begin
                  los_d = los_q + 1'b1;
                end
              end
            end else begin
              mon_cnt_d = mon_cnt_q + 1'b1;
              mon_err_d = mon_err_q + MerrW'(mis);
            end
          end
        end
        default: state_d = StIdle;
      endcase

      // Clear beats a same-cycle count and leaves the search state untouched
      if (i_clear) begin
        err_d = '0;
        tot_d = '0;
        los_d = '0;
      end
    end

    // Output decode from the registered state
    always_comb begin
      lock = (state_q == StLock);
    end

    assign o_lock[g]                       = lock;
    assign o_lat[g*NBT_LAT +: NBT_LAT]     = lat_q;
    assign o_err[g*NBT_CNT +: NBT_CNT]     = err_q;
    assign o_tot[g*NBT_CNT +: NBT_CNT]     = tot_q;
    assign o_los_cnt[g*8 +: 8]             = los_q;
  end

endmodule

// File: tb/tb_ber_counter_mc.sv
// tb_ber_counter_mc: directed phases with randomized noise/enable, checked every cycle
// against a strobe-level reference model, plus directed checks at each phase boundary.
module tb_ber_counter_mc;

  localparam int PrbsLen = 511;
  localparam int SynWin  = 64;
  localparam int SynThr  = 0;
  localparam int MonWin  = 128;
  localparam int LosThr  = 8;
  localparam int MIdle   = 0;
  localparam int MSearch = 1;
  localparam int MLock   = 2;

  logic         clk;
  logic         i_reset, i_enable, i_clear;
  logic [1:0]   i_ref, i_rx;
  logic [1:0]   lock_w, lock_s;
  logic [17:0]  lat_w, lat_s;
  logic [127:0] err_w, tot_w;
  logic [7:0]   err_s, tot_s;
  logic [15:0]  los_w, los_s;

  ber_counter_mc #(
    .NCH(2), .PRBS_LEN(PrbsLen), .START_SYN(0), .SYN_WIN(SynWin), .SYN_THR(SynThr),
    .MON_WIN(MonWin), .LOS_THR(LosThr), .NBT_CNT(64)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
    .i_ref(i_ref), .i_rx(i_rx), .o_lock(lock_w), .o_lat(lat_w), .o_err(err_w),
    .o_tot(tot_w), .o_los_cnt(los_w)
  );

  ber_counter_mc #(
    .NCH(2), .PRBS_LEN(PrbsLen), .START_SYN(0), .SYN_WIN(SynWin), .SYN_THR(SynThr),
    .MON_WIN(MonWin), .LOS_THR(LosThr), .NBT_CNT(4)
  ) dut_s (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear),
    .i_ref(i_ref), .i_rx(i_rx), .o_lock(lock_s), .o_lat(lat_s), .o_err(err_s),
    .o_tot(tot_s), .o_los_cnt(los_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  strobe = 0;
  int  dly [2];
  bit  prbs [PrbsLen];

  // Reference model state, one entry per lane
  int     m_mode [2];
  int     m_lat  [2];
  int     m_wcnt [2];
  int     m_werr [2];
  int     m_mcnt [2];
  int     m_merr [2];
  longint m_err  [2];
  longint m_tot  [2];
  int     m_los  [2];
  bit     m_hist [2][$];

  function automatic int pidx(input int v);
    return ((v % PrbsLen) + PrbsLen) % PrbsLen;
  endfunction

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit clr,
                            input bit [1:0] rf, input bit [1:0] rx);
    for (int l = 0; l < 2; l++) begin
      bit rb;
      bit mis;
      if (rst) begin
        m_mode[l] = MIdle;
        m_lat[l]  = 0;
        m_wcnt[l] = 0;
        m_werr[l] = 0;
        m_mcnt[l] = 0;
        m_merr[l] = 0;
        m_err[l]  = 0;
        m_tot[l]  = 0;
        m_los[l]  = 0;
        m_hist[l].delete();
      end else begin
        // Reference bit m_lat strobes ago; history before reset reads as zero
        if (m_lat[l] == 0) rb = rf[l];
        else if (m_lat[l] - 1 < int'(m_hist[l].size())) rb = m_hist[l][m_lat[l] - 1];
        else rb = 1'b0;
        mis = en && (rx[l] != rb);
        if (m_mode[l] == MIdle) begin
          m_mode[l] = MSearch;
        end else if (en && m_mode[l] == MSearch) begin
          m_wcnt[l] = m_wcnt[l] + 1;
          m_werr[l] = m_werr[l] + int'(mis);
          if (m_wcnt[l] == SynWin) begin
            if (m_werr[l] <= SynThr) begin
              m_mode[l] = MLock;
              m_mcnt[l] = 0;
              m_merr[l] = 0;
            end else begin
              m_lat[l] = (m_lat[l] + 1) % PrbsLen;
            end
            m_wcnt[l] = 0;
            m_werr[l] = 0;
          end
        end else if (en && m_mode[l] == MLock) begin
          m_tot[l]  = m_tot[l] + 1;
          m_err[l]  = m_err[l] + longint'(mis);
          m_mcnt[l] = m_mcnt[l] + 1;
          m_merr[l] = m_merr[l] + int'(mis);
          if (m_mcnt[l] == MonWin) begin
            if (m_merr[l] > LosThr) begin
              m_mode[l] = MSearch;
              m_lat[l]  = (m_lat[l] + 1) % PrbsLen;
              if (m_los[l] < 255) m_los[l] = m_los[l] + 1;
              m_wcnt[l] = 0;
              m_werr[l] = 0;
            end
            m_mcnt[l] = 0;
            m_merr[l] = 0;
          end
        end
        if (clr) begin
          m_err[l] = 0;
          m_tot[l] = 0;
          m_los[l] = 0;
        end
        if (en) begin
          m_hist[l].push_front(rf[l]);
          if (m_hist[l].size() > PrbsLen - 1) void'(m_hist[l].pop_back());
        end
      end
    end
  endtask

  task automatic check_all();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("lock%0d", l), 64'(lock_w[l]), 64'(m_mode[l] == MLock));
      chk($sformatf("lat%0d", l), 64'(lat_w[l*9 +: 9]), 64'(m_lat[l]));
      chk($sformatf("err%0d", l), err_w[l*64 +: 64], 64'(m_err[l]));
      chk($sformatf("tot%0d", l), tot_w[l*64 +: 64], 64'(m_tot[l]));
      chk($sformatf("los%0d", l), 64'(los_w[l*8 +: 8]), 64'(m_los[l]));
      chk($sformatf("s_lock%0d", l), 64'(lock_s[l]), 64'(m_mode[l] == MLock));
      chk($sformatf("s_err%0d", l), 64'(err_s[l*4 +: 4]), 64'(sat15(m_err[l])));
      chk($sformatf("s_tot%0d", l), 64'(tot_s[l*4 +: 4]), 64'(sat15(m_tot[l])));
    end
  endtask

  // One clock: drive lanes from the PRBS with per-lane delay and optional bit flips
  task automatic step(input bit en, input bit [1:0] flip);
    bit [1:0] rf, rx;
    for (int l = 0; l < 2; l++) begin
      rf[l] = prbs[pidx(strobe)];
      rx[l] = prbs[pidx(strobe - dly[l])] ^ flip[l];
    end
    i_enable = en;
    i_ref    = rf;
    i_rx     = rx;
    @(posedge clk);
    model_step(i_reset, en, i_clear, rf, rx);
    if (en && !i_reset) strobe++;
    #1;
    if (errors < 40) check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_lock"}, 64'(|lock_w), 64'd0);
    chk({tag, "_lat"}, 64'(|lat_w), 64'd0);
    chk({tag, "_err"}, 64'(|err_w), 64'd0);
    chk({tag, "_tot"}, 64'(|tot_w), 64'd0);
    chk({tag, "_los"}, 64'(|los_w), 64'd0);
    chk({tag, "_s_err"}, 64'(|err_s), 64'd0);
    chk({tag, "_s_tot"}, 64'(|tot_s), 64'd0);
  endtask

  initial begin
    bit [8:0] lfsr;
    bit       fb;
    lfsr = 9'h1ff;
    for (int i = 0; i < PrbsLen; i++) begin
      prbs[i] = lfsr[8];
      fb      = lfsr[8] ^ lfsr[4];
      lfsr    = {lfsr[7:0], fb};
    end

    i_reset  = 1'b1;
    i_clear  = 1'b0;
    i_enable = 1'b0;
    i_ref    = '0;
    i_rx     = '0;
    dly[0]   = 37;
    dly[1]   = 3;
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    check_zero("reset");

    // Lane0 delay 37, lane1 delay 3, clean bits
    i_reset = 1'b0;
    for (int i = 0; i < 3000 && !lock_w[0]; i++) step(1'b1, 2'b00);
    chk("t1_lock0", 64'(lock_w[0]), 64'd1);
    chk("t1_lock_strobes", 64'(strobe), 64'(1 + 38 * SynWin));
    chk("t1_lat0", 64'(lat_w[8:0]), 64'd37);
    chk("t1_lat1", 64'(lat_w[17:9]), 64'd3);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b00);
    chk("t1_tot0", tot_w[63:0], 64'd10);
    chk("t1_err0", err_w[63:0], 64'd0);

    // Clear on a strobe, then sparse errors on lane0 and random noise on lane1
    i_clear = 1'b1;
    step(1'b1, 2'b00);
    i_clear = 1'b0;
    chk("clr_err0", err_w[63:0], 64'd0);
    chk("clr_tot0", tot_w[63:0], 64'd0);
    for (int k = 0; k < 10000; k++) begin
      step(1'b1, {($urandom_range(0, 199) == 0), (k % 100 == 99)});
    end
    chk("t2_err0", err_w[63:0], 64'd100);
    chk("t2_tot0", tot_w[63:0], 64'd10000);
    chk("t2_lock0", 64'(lock_w[0]), 64'd1);
    chk("t2_los0", 64'(los_w[7:0]), 64'd0);
    chk("t6_sat_err0", 64'(err_s[3:0]), 64'd15);
    chk("t6_sat_tot0", 64'(tot_s[3:0]), 64'd15);

    // Counts advance only on enabled cycles
    step(1'b0, 2'b00);
    chk("en_low_tot0", tot_w[63:0], 64'd10000);
    step(1'b1, 2'b00);
    chk("en_high_tot0", tot_w[63:0], 64'd10001);
    for (int k = 0; k < 300; k++) begin
      step(bit'($urandom_range(0, 1)), {($urandom_range(0, 199) == 0), 1'b0});
    end

    // Invert lane0 until lock is lost
    for (int i = 0; i < 300 && lock_w[0]; i++) step(1'b1, 2'b01);
    chk("t3_lock0", 64'(lock_w[0]), 64'd0);
    chk("t3_los0", 64'(los_w[7:0]), 64'd1);
    chk("t3_lat0", 64'(lat_w[8:0]), 64'd38);
    chk("t3_lock1", 64'(lock_w[1]), 64'd1);
    for (int i = 0; i < 34000 && !lock_w[0]; i++) step(1'b1, 2'b00);
    chk("t3_relock0", 64'(lock_w[0]), 64'd1);
    chk("t3_relat0", 64'(lat_w[8:0]), 64'd37);
    chk("t3_los0_hold", 64'(los_w[7:0]), 64'd1);
    i_clear = 1'b1;
    step(1'b1, 2'b00);
    i_clear = 1'b0;
    chk("clr2_los0", 64'(los_w[7:0]), 64'd0);
    chk("clr2_tot0", tot_w[63:0], 64'd0);
    chk("clr2_lock0", 64'(lock_w[0]), 64'd1);
    chk("clr2_lat0", 64'(lat_w[8:0]), 64'd37);

    // Reset mid-lock, then lane0 at the far end of the search range
    i_reset = 1'b1;
    step(1'b1, 2'b00);
    check_zero("midrst");
    i_reset = 1'b0;
    dly[0]  = 510;
    dly[1]  = 3;
    for (int i = 0; i < 400 && !lock_w[1]; i++) step(1'b1, 2'b00);
    chk("t4_lock1", 64'(lock_w[1]), 64'd1);
    chk("t4_lat1", 64'(lat_w[17:9]), 64'd3);
    chk("t4_lock0_pending", 64'(lock_w[0]), 64'd0);
    for (int i = 0; i < 33500 && !lock_w[0]; i++) step(1'b1, 2'b00);
    chk("t4_lock0", 64'(lock_w[0]), 64'd1);
    chk("t4_lat0", 64'(lat_w[8:0]), 64'd510);
    chk("t4_err0", err_w[63:0], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
